// File: rtl/count_seq_pkg.sv
// Shared encodings for the count_sequencer command interface and its controller FSM.
package count_seq_pkg;

    localparam logic [1:0] OP_LOAD         = 2'b00;
    localparam logic [1:0] OP_UP_N         = 2'b01;
    localparam logic [1:0] OP_DOWN_N       = 2'b10;
    localparam logic [1:0] OP_SET_PRESCALE = 2'b11;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

endpackage

// File: rtl/count_core.sv
// WIDTH-bit up/down counter register with synchronous load and a look-ahead wrap flag.
module count_core #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             en,
    input  logic             up,
    output logic [WIDTH-1:0] count,
    output logic             wrap_next
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = load_val;
        end else if (en) begin
            count_d = up ? (count_q + WIDTH'(1)) : (count_q - WIDTH'(1));
        end
    end

    // High only when the step about to be taken crosses max->0 or 0->max.
    assign wrap_next = en && (up ? (&count_q) : (~|count_q));

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/count_sequencer.sv
// Command-driven controller: accepts load/step/prescale commands and paces the counter core.
module count_sequencer
    import count_seq_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter int PRESCALE_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [WIDTH-1:0] cmd_arg,
    input  logic             stop,
    output logic [WIDTH-1:0] count,
    output logic             busy,
    output logic             done,
    output logic             wrap
);

    state_e                state_q, state_d;
    logic [PRESCALE_W-1:0] prescale_q, prescale_d;
    logic [PRESCALE_W-1:0] tick_q, tick_d;
    logic [WIDTH-1:0]      remaining_q, remaining_d;
    logic                  dir_q, dir_d;
    logic                  done_q, done_d;
    logic                  wrap_q, wrap_d;

    logic accept;
    logic step_due;
    logic last_step;
    logic core_load;
    logic core_en;
    logic core_wrap_next;

    // A command is taken when valid meets ready; ready depends only on state and reset.
    assign accept    = cmd_valid && cmd_ready;
    assign step_due  = (state_q == ST_RUN) && !stop && (tick_q == prescale_q);
    assign last_step = step_due && (remaining_q == WIDTH'(1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (accept && (cmd_op == OP_UP_N || cmd_op == OP_DOWN_N) && (cmd_arg != '0)) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (stop || last_step) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        prescale_d  = prescale_q;
        tick_d      = tick_q;
        remaining_d = remaining_q;
        dir_d       = dir_q;
        core_load   = 1'b0;
        core_en     = 1'b0;
        done_d      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    case (cmd_op)
                        OP_LOAD: begin
                            core_load = 1'b1;
                            done_d    = 1'b1;
                        end
                        OP_SET_PRESCALE: begin
                            prescale_d = cmd_arg[PRESCALE_W-1:0];
                            done_d     = 1'b1;
                        end
                        default: begin
                            if (cmd_arg == '0) begin
                                done_d = 1'b1;
                            end else begin
                                remaining_d = cmd_arg;
                                tick_d      = '0;
                                dir_d       = (cmd_op == OP_UP_N);
                            end
                        end
                    endcase
                end
            end
            ST_RUN: begin
                if (step_due) begin
                    core_en     = 1'b1;
                    remaining_d = remaining_q - WIDTH'(1);
                    tick_d      = '0;
                    done_d      = last_step;
                end else if (!stop) begin
                    tick_d = tick_q + PRESCALE_W'(1);
                end
            end
            default: ;
        endcase
    end

    assign wrap_d = core_wrap_next;

    always_ff @(posedge clk) begin
        if (rst) begin
            prescale_q  <= '0;
            tick_q      <= '0;
            remaining_q <= '0;
            dir_q       <= 1'b0;
            done_q      <= 1'b0;
            wrap_q      <= 1'b0;
        end else begin
            prescale_q  <= prescale_d;
            tick_q      <= tick_d;
            remaining_q <= remaining_d;
            dir_q       <= dir_d;
            done_q      <= done_d;
            wrap_q      <= wrap_d;
        end
    end

    count_core #(
        .WIDTH(WIDTH)
    ) u_core (
        .clk      (clk),
        .rst      (rst),
        .load     (core_load),
        .load_val (cmd_arg),
        .en       (core_en),
        .up       (dir_q),
        .count    (count),
        .wrap_next(core_wrap_next)
    );

    assign cmd_ready = (state_q == ST_IDLE) && !rst;
    assign busy      = (state_q == ST_RUN);
    assign done      = done_q;
    assign wrap      = wrap_q;

endmodule

// File: tb/tb_count_sequencer.sv
// Directed bench for count_sequencer: inputs change and outputs are sampled on falling edges.
module tb_count_sequencer;

    logic       clk;
    logic       rst;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd_op;
    logic [7:0] cmd_arg;
    logic       stop;
    logic [7:0] count;
    logic       busy;
    logic       done;
    logic       wrap;

    int checks = 0;
    int errors = 0;

    count_sequencer #(
        .WIDTH     (8),
        .PRESCALE_W(8)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_op   (cmd_op),
        .cmd_arg  (cmd_arg),
        .stop     (stop),
        .count    (count),
        .busy     (busy),
        .done     (done),
        .wrap     (wrap)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Present one command for a single cycle; returns at the falling edge after the accept edge.
    task automatic issue(input logic [1:0] op, input logic [7:0] arg);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_arg   = arg;
        @(negedge clk);
        cmd_valid = 1'b0;
        cmd_op    = 2'b00;
        cmd_arg   = 8'h00;
    endtask

    initial begin
        rst       = 1'b1;
        cmd_valid = 1'b0;
        cmd_op    = 2'b00;
        cmd_arg   = 8'h00;
        stop      = 1'b0;

        // Reset state
        @(negedge clk);
        @(negedge clk);
        chk("rst_ready", cmd_ready, 1'b0);
        chk("rst_count", count, 8'h00);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_wrap", wrap, 1'b0);
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_ready", cmd_ready, 1'b1);

        // LOAD 0x5A
        issue(2'b00, 8'h5A);
        chk("load_count", count, 8'h5A);
        chk("load_done", done, 1'b1);
        chk("load_busy", busy, 1'b0);
        @(negedge clk);
        chk("load_done_clr", done, 1'b0);
        chk("load_busy2", busy, 1'b0);

        // Prescale 2, UP_N 3 from 0x10
        issue(2'b00, 8'h10);
        issue(2'b11, 8'h02);
        chk("pre_done", done, 1'b1);
        chk("pre_count", count, 8'h10);
        issue(2'b01, 8'h03);
        for (int i = 0; i < 9; i++) begin
            chk($sformatf("up3_count_%0d", i), count, 8'h10 + (i / 3));
            chk($sformatf("up3_busy_%0d", i), busy, 1'b1);
            chk($sformatf("up3_done_%0d", i), done, 1'b0);
            @(negedge clk);
        end
        chk("up3_final", count, 8'h13);
        chk("up3_final_done", done, 1'b1);
        chk("up3_final_busy", busy, 1'b0);
        chk("up3_final_ready", cmd_ready, 1'b1);
        @(negedge clk);
        chk("up3_done_clr", done, 1'b0);

        // LOAD 1, prescale 0, DOWN_N 3 through zero
        issue(2'b00, 8'h01);
        issue(2'b11, 8'h00);
        issue(2'b10, 8'h03);
        chk("dn_c0", count, 8'h01);
        chk("dn_busy0", busy, 1'b1);
        @(negedge clk);
        chk("dn_c1", count, 8'h00);
        chk("dn_w1", wrap, 1'b0);
        @(negedge clk);
        chk("dn_c2", count, 8'hFF);
        chk("dn_w2", wrap, 1'b1);
        chk("dn_d2", done, 1'b0);
        @(negedge clk);
        chk("dn_c3", count, 8'hFE);
        chk("dn_w3", wrap, 1'b0);
        chk("dn_d3", done, 1'b1);
        chk("dn_ready3", cmd_ready, 1'b1);

        // Back-to-back in the done cycle: LOAD 0xFF, then UP_N 1 wraps on the final step
        issue(2'b00, 8'hFF);
        chk("b2b_count", count, 8'hFF);
        issue(2'b01, 8'h01);
        chk("wr_busy0", busy, 1'b1);
        @(negedge clk);
        chk("wr_count", count, 8'h00);
        chk("wr_done", done, 1'b1);
        chk("wr_wrap", wrap, 1'b1);
        @(negedge clk);
        chk("wr_done_clr", done, 1'b0);
        chk("wr_wrap_clr", wrap, 1'b0);

        // UP_N 10 aborted after 4 steps
        issue(2'b01, 8'h0A);
        repeat (4) @(negedge clk);
        chk("stop_pre_count", count, 8'h04);
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        chk("stop_count", count, 8'h04);
        chk("stop_busy", busy, 1'b0);
        chk("stop_done", done, 1'b0);
        chk("stop_ready", cmd_ready, 1'b1);
        @(negedge clk);
        chk("stop_count_hold", count, 8'h04);
        chk("stop_done2", done, 1'b0);

        // Stop coinciding with the final step
        issue(2'b01, 8'h02);
        @(negedge clk);
        chk("stopfin_step1", count, 8'h05);
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        chk("stopfin_count", count, 8'h05);
        chk("stopfin_done", done, 1'b0);
        chk("stopfin_busy", busy, 1'b0);
        chk("stopfin_wrap", wrap, 1'b0);

        // Stop is ignored in IDLE
        stop = 1'b1;
        issue(2'b00, 8'h33);
        stop = 1'b0;
        chk("idle_stop_count", count, 8'h33);
        chk("idle_stop_done", done, 1'b1);

        // Reset in the middle of a run
        issue(2'b11, 8'h03);
        issue(2'b01, 8'h05);
        repeat (2) @(negedge clk);
        chk("mid_busy", busy, 1'b1);
        rst = 1'b1;
        @(negedge clk);
        chk("mrst_count", count, 8'h00);
        chk("mrst_busy", busy, 1'b0);
        chk("mrst_done", done, 1'b0);
        chk("mrst_ready", cmd_ready, 1'b0);
        rst = 1'b0;
        #1;
        chk("mrst_ready_rel", cmd_ready, 1'b1);
        @(negedge clk);
        chk("mrst_done_after", done, 1'b0);

        // Zero-step command, then prescale back at 0 gives a step on the next edge
        issue(2'b01, 8'h00);
        chk("zero_done", done, 1'b1);
        chk("zero_count", count, 8'h00);
        chk("zero_busy", busy, 1'b0);
        issue(2'b01, 8'h01);
        @(negedge clk);
        chk("prs_rst_count", count, 8'h01);
        chk("prs_rst_done", done, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/count_sequencer.md
# count_sequencer

Command-driven controller for the up/down counter datapath, sitting between the top-level I/O decode and the counter core. It accepts load, count-up-N, count-down-N and prescale commands over a valid/ready handshake. It sequences the counter one step every (prescale+1) clocks until the step budget is spent. It reports completion and wrap-around as single-cycle pulses.

## Interface
- WIDTH, 8: counter and command-argument width.
- PRESCALE_W, 8: prescale register width; must be ≤ WIDTH.

- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  high when a command can be accepted.
- cmd_op  in  2  00 LOAD, 01 UP_N, 10 DOWN_N, 11 SET_PRESCALE.
- cmd_arg  in  WIDTH  load value, step count, or prescale (low PRESCALE_W bits).
- stop  in  1  abort the running UP_N/DOWN_N.
- count  out  WIDTH  current counter value, registered.
- busy  out  1  high while in RUN.
- done  out  1  one-cycle pulse when a command completes.
- wrap  out  1  one-cycle pulse when a step crosses max→0 or 0→max.

## Operation
- States: IDLE, RUN.
- cmd_ready = (state==IDLE) && !rst.
- A command is accepted on an edge where cmd_valid && cmd_ready.
- Accepted in IDLE:
  - LOAD: count←cmd_arg; stay IDLE; done=1 next cycle.
  - SET_PRESCALE: prescale←cmd_arg[PRESCALE_W-1:0]; count unchanged; stay IDLE; done=1 next cycle.
  - UP_N/DOWN_N with cmd_arg=0: no step; stay IDLE; done=1 next cycle.
  - UP_N/DOWN_N with cmd_arg=N>0: remaining←N, tick←0, dir latched; go RUN.
- In RUN, each edge:
  - If stop: go IDLE, count holds, no done, no step.
  - Else if tick==prescale: count±1 modulo 2^WIDTH, remaining−1, tick←0. If remaining was 1, go IDLE and set done.
  - Else: tick+1.
- stop is ignored in IDLE.
- stop and the final step on the same edge: stop wins. No step, no done, no wrap.
- Arithmetic wraps modulo 2^WIDTH:
  - up from 2^WIDTH−1 gives 0 and sets wrap;
  - down from 0 gives 2^WIDTH−1 and sets wrap.
- A final step that also wraps pulses done and wrap in the same cycle.
- cmd_op/cmd_arg are don't-care when the command is not accepted.
- Commands presented during RUN stall; they are not dropped.

## Timing
- Reset values: count=0, prescale=0, state=IDLE, busy=0, done=0, wrap=0, cmd_ready=0 while rst=1, then 1 after the reset edge.
- rst asserted mid-RUN: all state returns to reset values at that edge; the command is abandoned with no done.
- UP_N/DOWN_N accepted at edge E0 with N steps and prescale P:
  - step k lands at edge E0+k·(P+1);
  - the final step lands at E0+N·(P+1);
  - after that edge: count is final, done=1, busy=0, cmd_ready=1, all in the same cycle.
- LOAD, SET_PRESCALE and zero-step commands: result and done visible in the cycle after the accept edge.
- Back-to-back: a new command may be accepted in the cycle done is high.
- done and wrap are registered and high for exactly one cycle.
- busy and cmd_ready are decoded from the state register only, with no combinational path from cmd_valid.

## Structure
- Package count_seq_pkg holds:
  - op encodings: OP_LOAD, OP_UP_N, OP_DOWN_N, OP_SET_PRESCALE;
  - state enum: ST_IDLE, ST_RUN.
- Sub-module count_core holds the WIDTH-bit register.
  - Inputs: load, load_val, en, up.
  - Outputs: count and a combinational wrap_next, true when en and the next step crosses a boundary.
  - count_sequencer registers wrap.
- count_sequencer owns the FSM, prescale/tick/remaining registers and handshake.

## Test plan
- Reset, then LOAD 0x5A → count=0x5A and done=1 for exactly 1 cycle, busy=0 throughout.
- SET_PRESCALE 2, then UP_N 3 from count=0x10 → count steps to 0x11/0x12/0x13 at accept+3/+6/+9. done rises with 0x13; busy high for 9 cycles.
- LOAD 0x01, prescale 0, DOWN_N 3 → count 0x00, 0xFF, 0xFE. wrap pulses once, after the 0x00→0xFF step. done after the 3rd step.
- LOAD 0xFF, UP_N 1 → count=0x00; done and wrap both high in the same single cycle.
- UP_N 10 with stop pulsed at accept+4 → count shows 4 steps taken, no done, busy=0, cmd_ready=1 next cycle. Also stop on the final-step edge → no step, no done.
- rst asserted during RUN → next cycle count=0, busy=0, done=0; UP_N 0 then gives done with count unchanged.
